// File: rtl/fault_injector.sv
// rtl/fault_injector.sv - instruction-fetch fault injector with detection scoreboard
// Optional feature: define FI_MULTI_BIT_EN for double-bit flips.
module fault_injector #(
    parameter int          MAX_INJ    = 10,
    parameter int          THRESH     = 36,
    parameter logic [31:0] ADDR_LIMIT = 32'h100,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] SEED       = 32'hACE1_2024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        rvalid_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o,
    input  logic        error_i,
    output logic        inj_active_o,
    output logic [7:0]  inj_count_o,
    output logic [7:0]  det_count_o,
    output logic [7:0]  miss_count_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WAIT_DET,
        DONE
    } state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] THRESH_W  = 32'(THRESH);
    localparam logic [31:0] MAX_W     = 32'(MAX_INJ);
    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    state_e      state_q;
    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic [31:0] tmr_q;
    logic [7:0]  inj_cnt_q;
    logic [7:0]  det_cnt_q;
    logic [7:0]  miss_cnt_q;
    logic        done_q;
    logic        inject;
    logic [31:0] mask;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Galois LFSR next value: shift right, fold taps in when the low bit falls out
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    end

    // Inject decision and corruption mask, both taken from the registered LFSR.
    // enable_i gates injection so a dropping arm request never corrupts a beat.
    always_comb begin
        inject = (state_q == ARMED) && enable_i && rvalid_i &&
                 (addr_i < ADDR_LIMIT) &&
                 ({24'd0, lfsr_q[7:0]} < THRESH_W) &&
                 ({24'd0, inj_cnt_q} < MAX_W);
        mask = 32'd1 << lfsr_q[12:8];
`ifdef FI_MULTI_BIT_EN
        mask = mask | (32'd1 << lfsr_q[17:13]);
`endif
    end

    // Zero-latency data path to the replica core
    always_comb begin
        rdata_o = inject ? (rdata_i ^ mask) : rdata_i;
    end

    assign inj_active_o = inject;
    assign inj_count_o  = inj_cnt_q;
    assign det_count_o  = det_cnt_q;
    assign miss_count_o = miss_cnt_q;
    assign done_o       = done_q;

    // Campaign FSM with its counters; enable_i low aborts to IDLE from anywhere
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            tmr_q      <= 32'd0;
            inj_cnt_q  <= 8'd0;
            det_cnt_q  <= 8'd0;
            miss_cnt_q <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            if (!enable_i) begin
                state_q <= IDLE;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q    <= ARMED;
                        inj_cnt_q  <= 8'd0;
                        det_cnt_q  <= 8'd0;
                        miss_cnt_q <= 8'd0;
                        done_q     <= 1'b0;
                    end
                    ARMED: begin
                        if (inject) begin
                            inj_cnt_q <= sat_inc(inj_cnt_q);
                            tmr_q     <= TIMEOUT_W;
                            state_q   <= WAIT_DET;
                        end
                    end
                    WAIT_DET: begin
                        // Detection wins over expiry when both land in the same cycle
                        if (error_i || (tmr_q <= 32'd1)) begin
                            if (error_i) begin
                                det_cnt_q <= sat_inc(det_cnt_q);
                            end else begin
                                miss_cnt_q <= sat_inc(miss_cnt_q);
                            end
                            if ({24'd0, inj_cnt_q} == MAX_W) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ARMED;
                            end
                        end else begin
                            tmr_q <= tmr_q - 32'd1;
                        end
                    end
                    DONE: begin
                        done_q <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fault_injector.sv
// tb/tb_fault_injector.sv - randomized model-checked bench for fault_injector
module tb_fault_injector;

    localparam int          MAXI  = 10;
    localparam int          TOUT  = 16;
    localparam logic [31:0] ALIM  = 32'h100;
    localparam logic [31:0] SEEDV = 32'hACE1_2024;
`ifdef FI_MULTI_BIT_EN
    localparam logic [31:0] EXP_FIRST = 32'h0001_0010;
`else
    localparam logic [31:0] EXP_FIRST = 32'h0001_0000;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        rvalid;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err_v [2];
    logic [31:0] rd_o  [2];
    logic        inj_o [2];
    logic [7:0]  ic_o  [2];
    logic [7:0]  dc_o  [2];
    logic [7:0]  mc_o  [2];
    logic        dn_o  [2];

    int checks = 0;
    int errors = 0;

    // instance 0 always wins the probability draw, instance 1 uses the default
    int th [2] = '{256, 36};

    logic [31:0] m_lfsr [2];
    bit          m_act  [2];
    bit          m_pend [2];
    bit          m_done [2];
    int          m_inj  [2];
    int          m_det  [2];
    int          m_miss [2];
    int          m_dead [2];
    int          m_icyc [2];
    int          err_mode [2];
    int          cyc;
    logic [31:0] diff_a;
    int          first_inj_cyc;
    int          first_miss_cyc;

    fault_injector #(.THRESH(256)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .rvalid_i(rvalid),
        .addr_i(addr), .rdata_i(rdata), .rdata_o(rd_o[0]), .error_i(err_v[0]),
        .inj_active_o(inj_o[0]), .inj_count_o(ic_o[0]), .det_count_o(dc_o[0]),
        .miss_count_o(mc_o[0]), .done_o(dn_o[0])
    );

    fault_injector u_b (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .rvalid_i(rvalid),
        .addr_i(addr), .rdata_i(rdata), .rdata_o(rd_o[1]), .error_i(err_v[1]),
        .inj_active_o(inj_o[1]), .inj_count_o(ic_o[1]), .det_count_o(dc_o[1]),
        .miss_count_o(mc_o[1]), .done_o(dn_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'd0);
    endfunction

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lfsr[k] = SEEDV; m_act[k] = 0; m_pend[k] = 0; m_done[k] = 0;
            m_inj[k] = 0; m_det[k] = 0; m_miss[k] = 0; m_dead[k] = 0; m_icyc[k] = 0;
        end
    endtask

    // Asynchronous reset pulse landing mid-cycle; outputs must clear before any edge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_inj_active[%0d]", k), 32'(inj_o[k]), 32'd0);
            chk($sformatf("rst_inj_count[%0d]", k), 32'(ic_o[k]), 32'd0);
            chk($sformatf("rst_det_count[%0d]", k), 32'(dc_o[k]), 32'd0);
            chk($sformatf("rst_miss_count[%0d]", k), 32'(mc_o[k]), 32'd0);
            chk($sformatf("rst_done[%0d]", k), 32'(dn_o[k]), 32'd0);
            chk($sformatf("rst_rdata[%0d]", k), rd_o[k], rdata);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock cycle: derive error inputs, compare at negedge, advance the model
    task automatic step();
        bit          e [2];
        bit          xi;
        logic [31:0] mask;
        int          nb;
        for (int k = 0; k < 2; k++) begin
            case (err_mode[k])
                1:       e[k] = m_pend[k] && (cyc == m_icyc[k] + 2);
                2:       e[k] = m_pend[k] && (cyc == m_dead[k]);
                3:       e[k] = ($urandom_range(0, 7) == 0);
                default: e[k] = 1'b0;
            endcase
            err_v[k] = e[k];
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            xi = en && m_act[k] && !m_pend[k] && !m_done[k] && rvalid &&
                 (addr < ALIM) && (int'(m_lfsr[k][7:0]) < th[k]) && (m_inj[k] < MAXI);
            mask = 32'd1 << m_lfsr[k][12:8];
            nb = 1;
`ifdef FI_MULTI_BIT_EN
            if (m_lfsr[k][17:13] != m_lfsr[k][12:8]) nb = 2;
            mask = mask | (32'd1 << m_lfsr[k][17:13]);
`endif
            chk($sformatf("inj_active[%0d]", k), 32'(inj_o[k]), 32'(xi));
            chk($sformatf("rdata[%0d]", k), rd_o[k], xi ? (rdata ^ mask) : rdata);
            chk($sformatf("inj_count[%0d]", k), 32'(ic_o[k]), 32'(m_inj[k]));
            chk($sformatf("det_count[%0d]", k), 32'(dc_o[k]), 32'(m_det[k]));
            chk($sformatf("miss_count[%0d]", k), 32'(mc_o[k]), 32'(m_miss[k]));
            chk($sformatf("done[%0d]", k), 32'(dn_o[k]), 32'(m_done[k]));
            if (xi) chk($sformatf("flip_bits[%0d]", k), $countones(rd_o[k] ^ rdata), nb);
            if (k == 0) begin
                diff_a = rd_o[0] ^ rdata;
                if (inj_o[0] && first_inj_cyc < 0) first_inj_cyc = cyc;
                if (mc_o[0] == 8'd1 && first_miss_cyc < 0) first_miss_cyc = cyc;
            end
            if (!en) begin
                m_act[k] = 0; m_pend[k] = 0; m_done[k] = 0;
            end else if (!m_act[k]) begin
                m_act[k] = 1; m_inj[k] = 0; m_det[k] = 0; m_miss[k] = 0;
            end else if (m_done[k]) begin
                m_done[k] = 1;
            end else if (m_pend[k]) begin
                if (e[k]) begin
                    m_det[k] = sat(m_det[k]); m_pend[k] = 0; m_done[k] = (m_inj[k] == MAXI);
                end else if (cyc == m_dead[k]) begin
                    m_miss[k] = sat(m_miss[k]); m_pend[k] = 0; m_done[k] = (m_inj[k] == MAXI);
                end
            end else if (xi) begin
                m_inj[k] = sat(m_inj[k]); m_pend[k] = 1;
                m_dead[k] = cyc + TOUT; m_icyc[k] = cyc;
            end
            m_lfsr[k] = lfsr_next(m_lfsr[k]);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic rearm();
        en = 1'b0; step();
        en = 1'b1;
    endtask

    initial begin
        cyc = 0;
        first_inj_cyc = -1;
        first_miss_cyc = -1;
        rst_n = 1'b0; en = 1'b0; rvalid = 1'b0; addr = 32'h0; rdata = 32'h0;
        err_v[0] = 1'b0; err_v[1] = 1'b0;
        err_mode[0] = 0; err_mode[1] = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // disabled streaming: pure pass-through, counters stay clear
        err_mode[0] = 3; err_mode[1] = 3;
        rvalid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rdata = $urandom; addr = $urandom_range(0, 32'h1FF);
            step();
        end
        chk("idle_inj_count", 32'(ic_o[0]), 32'd0);
        chk("idle_det_count", 32'(dc_o[0]), 32'd0);

        // full campaign with detection two cycles after each injection
        do_reset();
        en = 1'b1; rvalid = 1'b1; addr = 32'h40;
        err_mode[0] = 1; err_mode[1] = 1;
        rdata = $urandom; step();
        rdata = $urandom; step();
        chk("first_bit_after_reset", diff_a, EXP_FIRST);
        for (int i = 0; i < 80; i++) begin
            rdata = $urandom; step();
        end
        chk("campaign_inj", 32'(ic_o[0]), 32'd10);
        chk("campaign_det", 32'(dc_o[0]), 32'd10);
        chk("campaign_miss", 32'(mc_o[0]), 32'd0);
        chk("campaign_done", 32'(dn_o[0]), 32'd1);

        // address at the limit is never eligible
        addr = ALIM;
        rearm();
        for (int i = 0; i < 60; i++) begin
            rdata = $urandom; step();
        end
        chk("addr_limit_inj", 32'(ic_o[0]), 32'd0);

        // timeout latency, then error exactly at expiry counts as detected
        addr = 32'h40;
        err_mode[0] = 0; err_mode[1] = 0;
        first_inj_cyc = -1; first_miss_cyc = -1;
        rearm();
        for (int i = 0; i < 60 && first_miss_cyc < 0; i++) begin
            rdata = $urandom; step();
        end
        chk("miss_latency", 32'(first_miss_cyc - first_inj_cyc), 32'(TOUT + 1));
        err_mode[0] = 2;
        for (int i = 0; i < 20; i++) begin
            rdata = $urandom; step();
        end
        chk("expiry_det", 32'(dc_o[0]), 32'd1);
        chk("expiry_miss", 32'(mc_o[0]), 32'd1);

        // abort three cycles into WAIT_DET, counters hold, then clear on re-arm
        err_mode[0] = 0;
        rearm();
        for (int i = 0; i < 5; i++) begin
            rdata = $urandom; step();
        end
        en = 1'b0; step();
        chk("abort_hold_inj", 32'(ic_o[0]), 32'd1);
        chk("abort_hold_miss", 32'(mc_o[0]), 32'd0);
        chk("abort_hold_det", 32'(dc_o[0]), 32'd0);
        en = 1'b1; step();
        chk("rearm_inj_clear", 32'(ic_o[0]), 32'd0);
        chk("rearm_done", 32'(dn_o[0]), 32'd0);

        // async reset while a fault is outstanding; sequence restarts from seed
        rdata = $urandom; step();
        rdata = $urandom; step();
        do_reset();
        rdata = $urandom; step();
        rdata = $urandom; step();
        chk("first_bit_reproducible", diff_a, EXP_FIRST);

        // randomized traffic
        err_mode[0] = 3; err_mode[1] = 3;
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 49) != 0);
            rvalid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0: addr = 32'h0;
                1: addr = 32'h40;
                2: addr = 32'hFF;
                3: addr = 32'h100;
                4: addr = 32'h101;
                default: addr = $urandom;
            endcase
            rdata = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
